seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of DIGITS common-anode 7-segment digits (Nexys 4 DDR style, 8 digits), with per-digit blanking, decimal points and leading-zero suppression. It latches a packed BCD/hex word into a shadow register and decodes it. It scans one digit at a time at a programmable refresh rate and drives active-low segment and anode lines. It sits between the clock/counter datapath and the board pins, replacing per-digit combinational decoders.

---
 rtl/seg7_scan_driver.sv | 156 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: shadowed value/dp/blank, leading-zero
// suppression, anti-ghosting dead cycle. Define SEG7_HEX_EN to display A-F glyphs.
module seg7_scan_driver #(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic                  DP,
    output logic [DIGITS-1:0]     AN
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_OFF  = 7'b1111111;

    // Segment pattern {CA..CG}, active low; unsupported glyphs stay dark.
    function automatic logic [6:0] decode_nibble(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'b0000001;
            4'd1:    pat = 7'b1001111;
            4'd2:    pat = 7'b0010010;
            4'd3:    pat = 7'b0000110;
            4'd4:    pat = 7'b1001100;
            4'd5:    pat = 7'b0100100;
            4'd6:    pat = 7'b0100000;
            4'd7:    pat = 7'b0001111;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0001100;
`ifdef SEG7_HEX_EN
            4'd10:   pat = 7'b0001000;
            4'd11:   pat = 7'b1100000;
            4'd12:   pat = 7'b0110001;
            4'd13:   pat = 7'b1000010;
            4'd14:   pat = 7'b0110000;
            4'd15:   pat = 7'b0111000;
`endif
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

    logic [PRE_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   value_q, value_d;
    logic [DIGITS-1:0]     dp_sh_q, dp_sh_d;
    logic [DIGITS-1:0]     blank_q, blank_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;

    logic                  tick_s;
    logic [DIGITS-1:0]     zero_from_s;
    logic [3:0]            cur_nib_s;
    logic                  dark_s;

    // zero_from_s[i]: nibbles i..DIGITS-1 of the shadow are all zero.
    always_comb begin
        zero_from_s = {DIGITS{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            zero_from_s[i] = ((value_q >> (4 * i)) == {(4*DIGITS){1'b0}});
        end
    end

    // Current digit nibble and darkness (blank or leading-zero suppressed).
    always_comb begin
        cur_nib_s = value_q[4*idx_q +: 4];
        dark_s    = blank_q[idx_q] |
                    (lz_en & (idx_q != {IDX_W{1'b0}}) & zero_from_s[idx_q]);
    end

    // Shadow capture: only a load strobe samples the inputs, regardless of enable.
    always_comb begin
        if (load) begin
            value_d  = value_in;
            dp_sh_d  = dp_in;
            blank_d  = blank_in;
        end else begin
            value_d  = value_q;
            dp_sh_d  = dp_sh_q;
            blank_d  = blank_q;
        end
    end

    // Scan sequencing and next output image; the tick edge drives a dark dead cycle.
    always_comb begin
        tick_s  = (presc_q == PRE_LAST);
        presc_d = presc_q;
        idx_d   = idx_q;
        seg_d   = SEG_OFF;
        dp_d    = 1'b1;
        an_d    = {DIGITS{1'b1}};
        if (enable) begin
            if (tick_s) begin
                presc_d = {PRE_W{1'b0}};
                if (idx_q == IDX_LAST) begin
                    idx_d = {IDX_W{1'b0}};
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else begin
                presc_d       = presc_q + PRE_W'(1);
                // Anode stays low even for a dark digit so every slot has equal duty.
                an_d[idx_q]   = 1'b0;
                if (dark_s) begin
                    seg_d = SEG_OFF;
                    dp_d  = 1'b1;
                end else begin
                    seg_d = decode_nibble(cur_nib_s);
                    dp_d  = ~dp_sh_q[idx_q];
                end
            end
        end else begin
            presc_d = presc_q;
            idx_d   = idx_q;
        end
    end

    // State and output registers; reset leaves the shadow blanked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= {PRE_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            value_q <= {(4*DIGITS){1'b0}};
            dp_sh_q <= {DIGITS{1'b0}};
            blank_q <= {DIGITS{1'b1}};
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            an_q    <= {DIGITS{1'b1}};
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            value_q <= value_d;
            dp_sh_q <= dp_sh_d;
            blank_q <= blank_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign seg = seg_q;
    assign DP  = dp_q;
    assign AN  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4): directed steps
// followed by random traffic, compared every cycle against a slot/phase reference model.
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          load;
    logic [15:0]   value_in;
    logic [3:0]    dp_in;
    logic [3:0]    blank_in;
    logic          lz_en;
    logic [6:0]    seg;
    logic          dp_o;
    logic [3:0]    an_o;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .load     (load),
        .value_in (value_in),
        .dp_in    (dp_in),
        .blank_in (blank_in),
        .lz_en    (lz_en),
        .seg      (seg),
        .DP       (dp_o),
        .AN       (an_o)
    );

    always #5 clk = ~clk;

    // Reference model: shadow contents plus the count of enabled edges since reset.
    logic [6:0]  font [16];
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;
    int          run;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_an;

    task automatic model_reset();
        m_val   = 16'h0000;
        m_dp    = 4'b0000;
        m_blank = 4'b1111;
        run     = 0;
        exp_seg = 7'b1111111;
        exp_dp  = 1'b1;
        exp_an  = 4'b1111;
    endtask

    task automatic model_edge();
        int ph;
        int sl;
        logic dark;
        logic [3:0] nib;
        exp_seg = 7'b1111111;
        exp_dp  = 1'b1;
        exp_an  = 4'b1111;
        if (enable) begin
            ph = run % RD;
            sl = (run / RD) % D;
            if (ph != RD - 1) begin
                exp_an[sl] = 1'b0;
                nib  = m_val[4*sl +: 4];
                dark = m_blank[sl] || (lz_en && sl != 0 && ((m_val >> (4*sl)) == 16'd0));
                if (!dark) begin
                    exp_seg = font[nib];
                    exp_dp  = ~m_dp[sl];
                end
            end
            run++;
        end
        if (load) begin
            m_val   = value_in;
            m_dp    = dp_in;
            m_blank = blank_in;
        end
    endtask

    task automatic check_outputs(input string tag);
        checks++;
        assert (seg === exp_seg) else begin
            errors++;
            $error("FAIL %s seg observed=%b expected=%b (run=%0d)", tag, seg, exp_seg, run);
        end
        checks++;
        assert (dp_o === exp_dp) else begin
            errors++;
            $error("FAIL %s DP observed=%b expected=%b (run=%0d)", tag, dp_o, exp_dp, run);
        end
        checks++;
        assert (an_o === exp_an) else begin
            errors++;
            $error("FAIL %s AN observed=%b expected=%b (run=%0d)", tag, an_o, exp_an, run);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic cycles(input int n, input string tag);
        for (int k = 0; k < n; k++) cycle(tag);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                           input string tag);
        value_in = v;
        dp_in    = dp;
        blank_in = bl;
        load     = 1'b1;
        cycle(tag);
        load     = 1'b0;
    endtask

    initial begin
        font[0]  = 7'b0000001; font[1]  = 7'b1001111; font[2]  = 7'b0010010;
        font[3]  = 7'b0000110; font[4]  = 7'b1001100; font[5]  = 7'b0100100;
        font[6]  = 7'b0100000; font[7]  = 7'b0001111; font[8]  = 7'b0000000;
        font[9]  = 7'b0001100;
`ifdef SEG7_HEX_EN
        font[10] = 7'b0001000; font[11] = 7'b1100000; font[12] = 7'b0110001;
        font[13] = 7'b1000010; font[14] = 7'b0110000; font[15] = 7'b0111000;
`else
        for (int f = 10; f < 16; f++) font[f] = 7'b1111111;
`endif

        rst_n = 1'b0; enable = 1'b0; load = 1'b0; lz_en = 1'b0;
        value_in = 16'h0000; dp_in = 4'b0000; blank_in = 4'b0000;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Scan 0x1234: AN rotates with a dead cycle between slots.
        enable = 1'b1;
        do_load(16'h1234, 4'b0000, 4'b0000, "load1234");
        cycles(32, "scan1234");

        // Leading-zero suppression on and off.
        lz_en = 1'b1;
        do_load(16'h0005, 4'b0000, 4'b0000, "load0005");
        cycles(16, "lz_on");
        lz_en = 1'b0;
        cycles(16, "lz_off");

        // Hex nibble with decimal point, zero below it.
        lz_en = 1'b1;
        do_load(16'h00A0, 4'b0010, 4'b0000, "load00A0");
        cycles(16, "hex_dp");
        lz_en = 1'b0;

        // Load coincident with the tick that precedes digit 2.
        while ((run % (D*RD)) != (2*RD - 1)) cycle("align_tick");
        do_load(16'h7981, 4'b0100, 4'b0000, "load_on_tick");
        cycles(16, "after_tick_load");

        // Pause mid-slot, load while paused, then resume.
        while ((run % RD) != 1) cycle("align_pause");
        enable = 1'b0;
        cycles(2, "paused");
        do_load(16'h3456, 4'b1001, 4'b0010, "load_paused");
        cycles(2, "paused2");
        enable = 1'b1;
        cycles(16, "resumed");

        // Asynchronous reset mid-frame.
        cycles(5, "pre_reset");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        @(posedge clk);
        #1;
        check_outputs("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        cycles(16, "post_reset_dark");
        do_load(16'h0042, 4'b0001, 4'b0000, "load_post_reset");
        cycles(16, "post_reset_scan");

        // Random traffic.
        for (int r = 0; r < 600; r++) begin
            enable = ($urandom_range(9, 0) != 0);
            if ($urandom_range(7, 0) == 0) lz_en = ~lz_en;
            if ($urandom_range(5, 0) == 0) begin
                value_in = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(3, 0)));
                dp_in    = 4'($urandom);
                blank_in = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'b0000;
                load     = 1'b1;
            end else begin
                load     = 1'b0;
            end
            cycle("random");
        end
        load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
